crypto_ctrl: RTL
================

Name: crypto_ctrl

Overview:
- Sits directly downstream of the USB memory-bus bridge in the clk_sys domain.
- Consumes the host-written input memory (key, plaintext, go byte) and drives the crypto core's start/key/text interface.
- Waits for the core to finish, then publishes ciphertext, status and a cycle count on the output memory bus that the bridge reads back.
- Provides the scope trigger that frames each operation.

Parameters:
- MEMORY_WIDTH, 8, log2 of memory section size in bytes.
- MEMORY_BYTES, 1<<MEMORY_WIDTH, bytes per memory bus.
- KEY_BYTES, 16, key length in bytes.
- TEXT_BYTES, 16, plaintext/ciphertext length in bytes.
- KEY_OFFSET, 'h00, byte index of key LSB in memory_input.
- TEXT_OFFSET, 'h10, byte index of plaintext LSB in memory_input.
- GO_OFFSET, 'h20, byte index of go byte in memory_input; bit0 is used.
- STATUS_OFFSET, 'h10, byte index of status byte in memory_output.
- CYCLES_OFFSET, 'h11, byte index of 16-bit little-endian cycle count in memory_output.
- TIMEOUT_CYCLES, 4096, WAIT-state limit; used only with the optional feature.

Ports:
- clk_sys  in  1  buffered system clock.
- reset_n  in  1  asynchronous, active-low reset.
- memory_input  in  MEMORY_BYTES*8  host-written bytes; asynchronous to clk_sys.
- memory_output  out  MEMORY_BYTES*8  bytes for host readback.
- crypto_key  out  KEY_BYTES*8  snapshotted key.
- crypto_textin  out  TEXT_BYTES*8  snapshotted plaintext.
- crypto_start  out  1  one-cycle start pulse.
- crypto_done  in  1  core completion, high for 1 or more cycles.
- crypto_textout  in  TEXT_BYTES*8  core result; valid while crypto_done=1.
- trigger_out  out  1  high while an operation is in flight.

Behaviour:
- Reset (async assert, sync release): all outputs 0, state IDLE, sync flops 0, status 0, cycle count 0.
- Go synchroniser: memory_input GO_OFFSET bit0 -> 2 flops -> delay flop. go_rise = sync2 & ~delayed.
  - Only a 0->1 transition starts an operation. The host must write 0 to re-arm.
- State machine, one-hot or binary:
  - IDLE: on go_rise -> LOAD; clear status.done and status.timeout; set status.busy.
  - LOAD (1 cycle): capture crypto_key and crypto_textin from their offsets -> START.
  - START (1 cycle): crypto_start=1, trigger_out=1, cycle counter=0 -> WAIT.
  - WAIT: trigger_out=1; counter increments each cycle, saturating at 'hFFFF.
    - On crypto_done=1: the count includes that cycle; capture crypto_textout -> CAPTURE.
  - CAPTURE (1 cycle): trigger_out=0; publish ciphertext and count; status.busy=0, status.done=1 -> IDLE.
- Latency: go bit stable before clk edge E1 -> go_rise true between E2 and E3 -> LOAD after E3 -> crypto_start high for the one cycle after E4.
- go_rise outside IDLE: ignored; sets status.overrun (sticky). Overrun clears only on reset.
- crypto_done outside WAIT: ignored.
- crypto_done in the START cycle: not sampled; WAIT then samples it if still high.
- memory_output map:
  - Bytes 0..TEXT_BYTES-1 = last ciphertext (byte 0 = textout[7:0]).
  - STATUS_OFFSET bits: 0 busy, 1 done, 2 overrun, 3 timeout; bits 7:4 = 0.
  - CYCLES_OFFSET (LSB), CYCLES_OFFSET+1 (MSB) = count.
  - All other bytes 0.
  - Fields are registered and change only in CAPTURE, the timeout exit, or on status-bit updates.
- crypto_key and crypto_textin hold their values until the next LOAD. Host writes during an operation do not disturb the core.
- Reset mid-operation: immediate return to IDLE; crypto_start and trigger_out drop asynchronously.

Optional Feature:
- Macro: CRYPTO_CTRL_TIMEOUT_EN.
- Defined:
  - In WAIT, if counter reaches TIMEOUT_CYCLES with no crypto_done -> IDLE.
  - Sets status.timeout=1, busy=0, done=0; trigger_out=0.
  - Ciphertext bytes are unchanged; count reads TIMEOUT_CYCLES.
- Undefined: WAIT lasts indefinitely and status bit 3 is always 0.

Test Plan:
- Normal op: key 000102..0F, text 00112233..FF, go 0->1; core asserts done in 10th WAIT cycle with textout 69C4E0D8..C55A -> crypto_start single pulse after E4; trigger_out high 11 cycles; ciphertext bytes 0..15 = textout; status='h02; count=10.
- Re-arm: keep go=1 after completion -> no new start. Write go=0 then 1 -> second operation runs; status.done=0 during it.
- Overrun: go 1->0->1 while in WAIT -> only one crypto_start; status='h05 during op, 'h06 after.
- Snapshot: rewrite key to all 'hFF during WAIT -> crypto_key still 000102..0F.
- Reset mid-WAIT: deassert reset_n -> trigger_out and memory_output = 0 immediately; a later go edge operates normally.
- Timeout (CRYPTO_CTRL_TIMEOUT_EN, TIMEOUT_CYCLES=16): no done -> status='h08, count=16, ciphertext unchanged, trigger_out low. Same stimulus without the macro: still busy after 1000 cycles.

Source files
------------

// File: rtl/crypto_ctrl.sv
// crypto_ctrl: runs one crypto-core operation per host go edge and publishes ciphertext/status/count.
// Optional WAIT timeout is compiled in when CRYPTO_CTRL_TIMEOUT_EN is defined.
module crypto_ctrl #(
    parameter int MEMORY_WIDTH   = 8,
    parameter int MEMORY_BYTES   = 1 << MEMORY_WIDTH,
    parameter int KEY_BYTES      = 16,
    parameter int TEXT_BYTES     = 16,
    parameter int KEY_OFFSET     = 'h00,
    parameter int TEXT_OFFSET    = 'h10,
    parameter int GO_OFFSET      = 'h20,
    parameter int STATUS_OFFSET  = 'h10,
    parameter int CYCLES_OFFSET  = 'h11,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                      clk_sys,
    input  logic                      reset_n,
    input  logic [MEMORY_BYTES*8-1:0] memory_input,
    output logic [MEMORY_BYTES*8-1:0] memory_output,
    output logic [KEY_BYTES*8-1:0]    crypto_key,
    output logic [TEXT_BYTES*8-1:0]   crypto_textin,
    output logic                      crypto_start,
    input  logic                      crypto_done,
    input  logic [TEXT_BYTES*8-1:0]   crypto_textout,
    output logic                      trigger_out
);

    localparam int KW = KEY_BYTES * 8;
    localparam int TW = TEXT_BYTES * 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT,
        S_CAPTURE
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      go_pipe;      // [0] sync1, [1] sync2, [2] edge-detect delay
    logic            go_rise;
    logic            load_en, publish_en;
    logic [15:0]     cnt_q, cnt_inc, count_q;
    logic [TW-1:0]   result_q, cipher_q;
    logic            status_busy, status_done, status_overrun, status_timeout;
    logic            unused_mem;

    assign go_rise = go_pipe[1] & ~go_pipe[2];
    assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            go_pipe <= '0;
        end else begin
            state_q <= state_d;
            go_pipe <= {go_pipe[1:0], memory_input[GO_OFFSET*8]};
        end
    end

`ifdef CRYPTO_CTRL_TIMEOUT_EN
    localparam logic [31:0] TIMEOUT_LIM = 32'(TIMEOUT_CYCLES);
    logic timeout_hit;
`endif

    // Strobes decode straight from state so reset drops them without a clock.
    always_comb begin
        state_d      = state_q;
        crypto_start = 1'b0;
        trigger_out  = 1'b0;
        load_en      = 1'b0;
        publish_en   = 1'b0;
`ifdef CRYPTO_CTRL_TIMEOUT_EN
        timeout_hit  = 1'b0;
`endif
        case (state_q)
            S_IDLE:    if (go_rise) state_d = S_LOAD;
            S_LOAD: begin
                load_en = 1'b1;
                state_d = S_START;
            end
            S_START: begin
                crypto_start = 1'b1;
                trigger_out  = 1'b1;
                state_d      = S_WAIT;
            end
            S_WAIT: begin
                trigger_out = 1'b1;
                if (crypto_done) state_d = S_CAPTURE;
`ifdef CRYPTO_CTRL_TIMEOUT_EN
                else if ({16'd0, cnt_inc} == TIMEOUT_LIM) begin
                    timeout_hit = 1'b1;
                    state_d     = S_IDLE;
                end
`endif
            end
            S_CAPTURE: begin
                publish_en = 1'b1;
                state_d    = S_IDLE;
            end
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            crypto_key     <= '0;
            crypto_textin  <= '0;
            cnt_q          <= '0;
            count_q        <= '0;
            result_q       <= '0;
            cipher_q       <= '0;
            status_busy    <= 1'b0;
            status_done    <= 1'b0;
            status_overrun <= 1'b0;
        end else begin
            if (go_rise && state_q == S_IDLE) begin
                status_busy <= 1'b1;
                status_done <= 1'b0;
            end
            if (go_rise && state_q != S_IDLE) status_overrun <= 1'b1;
            if (load_en) begin
                crypto_key    <= memory_input[KEY_OFFSET*8 +: KW];
                crypto_textin <= memory_input[TEXT_OFFSET*8 +: TW];
            end
            if (crypto_start)             cnt_q <= '0;
            else if (state_q == S_WAIT)   cnt_q <= cnt_inc;
            if (state_q == S_WAIT && crypto_done) result_q <= crypto_textout;
            if (publish_en) begin
                cipher_q    <= result_q;
                count_q     <= cnt_q;
                status_busy <= 1'b0;
                status_done <= 1'b1;
            end
`ifdef CRYPTO_CTRL_TIMEOUT_EN
            if (timeout_hit) begin
                count_q     <= cnt_inc;
                status_busy <= 1'b0;
                status_done <= 1'b0;
            end
`endif
        end
    end

`ifdef CRYPTO_CTRL_TIMEOUT_EN
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)                         status_timeout <= 1'b0;
        else if (timeout_hit)                 status_timeout <= 1'b1;
        else if (go_rise && state_q == S_IDLE) status_timeout <= 1'b0;
    end
    assign unused_mem = ^memory_input;
`else
    assign status_timeout = 1'b0;
    assign unused_mem     = ^{memory_input, TIMEOUT_CYCLES[0]};
`endif

    always_comb begin
        memory_output = '0;
        memory_output[0 +: TW] = cipher_q;
        memory_output[STATUS_OFFSET*8 +: 8] =
            {4'b0, status_timeout, status_overrun, status_done, status_busy};
        memory_output[CYCLES_OFFSET*8 +: 16] = count_q;
    end

endmodule
